// File: rtl/biu_arb_ctl_pkg.sv
// Shared definitions for the BIU arbiter/sequencer: FSM states, burst length,
// transfer size codes and default tuning parameters.
package biu_arb_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int BURST_BEATS = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/biu_ack_wdog.sv
// Ack watchdog: counts enabled cycles, clears on request, and flags when the
// count reaches LIMIT. LIMIT of 0 disables the expire flag entirely.
module biu_ack_wdog #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Saturate so a disabled watchdog never wraps back into a false match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (LIMIT != 0) && (cnt_q == LIMIT_W);

endmodule

// File: rtl/biu_arb_ctl.sv
// BIU control: arbitrates ICU/DCU requests (DCU priority with ICU anti-starvation),
// sequences single/burst pj bus transactions, routes acks and aborts on ack timeout.
module biu_arb_ctl
  import biu_arb_ctl_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       icu_req,
  input  logic       icu_burst,
  input  logic       dcu_req,
  input  logic       dcu_wr,
  input  logic       dcu_burst,
  input  logic [1:0] dcu_size,
  output logic       pj_tv,
  output logic       pj_rw,
  output logic       pj_burst,
  output logic [1:0] pj_size,
  input  logic       pj_ack,
  output logic       arb_select,
  output logic       biu_icu_ack,
  output logic       biu_dcu_ack,
  output logic       biu_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] LAST_BEAT  = 2'(BURST_BEATS - 1);

  state_e     state_q, state_d;
  logic       arb_select_q, arb_select_d;
  logic       pj_rw_q, pj_rw_d;
  logic       pj_burst_q, pj_burst_d;
  logic [1:0] pj_size_q, pj_size_d;
  logic       biu_err_q, biu_err_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] beat_cnt_q, beat_cnt_d;

  logic in_xfer;
  logic beat_ack;
  logic wdog_expired;

  assign in_xfer  = (state_q == XFER);
  assign beat_ack = in_xfer && pj_ack;

  biu_ack_wdog #(
    .WIDTH (8),
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (reset_l),
    .clr     (!in_xfer || pj_ack),
    .en      (in_xfer && !pj_ack),
    .expired (wdog_expired)
  );

  always_comb begin
    state_d      = state_q;
    arb_select_d = arb_select_q;
    pj_rw_d      = pj_rw_q;
    pj_burst_d   = pj_burst_q;
    pj_size_d    = pj_size_q;
    biu_err_d    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    beat_cnt_d   = beat_cnt_q;

    case (state_q)
      IDLE: begin
        if (icu_req || dcu_req) begin
          state_d = XFER;
          if (icu_req && (!dcu_req || (starve_cnt_q == STARVE_LIM))) begin
            arb_select_d = 1'b1;
            pj_rw_d      = 1'b0;
            pj_burst_d   = icu_burst;
            pj_size_d    = SIZE_WORD;
            starve_cnt_d = '0;
          end else begin
            arb_select_d = 1'b0;
            pj_rw_d      = dcu_wr;
            pj_burst_d   = dcu_burst;
            pj_size_d    = dcu_burst ? SIZE_WORD : dcu_size;
            if (icu_req && (starve_cnt_q < STARVE_LIM)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end

      // An ack in the expiry cycle still counts as a beat and suppresses the abort.
      XFER: begin
        if (pj_ack) begin
          if (!pj_burst_q || (beat_cnt_q == LAST_BEAT)) begin
            state_d    = DONE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end else if (wdog_expired) begin
          state_d    = DONE;
          biu_err_d  = 1'b1;
          beat_cnt_d = '0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      arb_select_q <= 1'b0;
      pj_rw_q      <= 1'b0;
      pj_burst_q   <= 1'b0;
      pj_size_q    <= SIZE_WORD;
      biu_err_q    <= 1'b0;
      starve_cnt_q <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      arb_select_q <= arb_select_d;
      pj_rw_q      <= pj_rw_d;
      pj_burst_q   <= pj_burst_d;
      pj_size_q    <= pj_size_d;
      biu_err_q    <= biu_err_d;
      starve_cnt_q <= starve_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign pj_tv       = in_xfer;
  assign pj_rw       = pj_rw_q;
  assign pj_burst    = pj_burst_q;
  assign pj_size     = pj_size_q;
  assign arb_select  = arb_select_q;
  assign biu_err     = biu_err_q;
  assign biu_icu_ack = beat_ack && arb_select_q;
  assign biu_dcu_ack = beat_ack && !arb_select_q;

endmodule
